mouse_event_fifo: RTL and testbench
===================================

// Module: mouse_event_fifo
// PURPOSE
//  Consumer of the 28-bit PS/2 mouse status word {run, btns[2:0], 2'b0, y[9:0], 2'b0, x[9:0]}.
//  Detects changes in position and buttons, and rate-limits motion-only changes.
//  Queues the changes as absolute-position events in a small FIFO.
//  The CPU drains the FIFO through one 32-bit IO read port, so it no longer has to poll
//  the live word and risk missing button edges.
// PARAMETERS
//  DEPTH    16     FIFO entries; power of two, minimum 2
//  AW       4      log2(DEPTH)
//  MIN_GAP  25000  minimum clk cycles between motion-only pushes (1 ms @ 25 MHz); 0 = no limit
//  GW       15     gap counter width; must hold MIN_GAP
// PORTS
//  clk     in   1     system clock; everything is on the rising edge
//  rst     in   1     asynchronous, active-low reset
//  ms_in   in   28    mouse status word, same clock domain
//  rd      in   1     one-cycle pop strobe from the IO decoder
//  rdata   out  32    {nonempty, ovf, 7'b0, btns[2:0], y[9:0], x[9:0]} of the FIFO head
//  level   out  AW+1  number of valid entries, 0..DEPTH
//  irq     out  1     equals nonempty
// BEHAVIOUR
//  Reset (rst=0, async)
//   - All of the following go to 0: pointers, level, ovf, gap counter, pending, snapshot,
//     and the input register.
//   - Resulting outputs: rdata = 0, level = 0, irq = 0.
//  Input stage
//   - ms_in is registered once into m.
//   - All detection below uses m.
//   - Fields: run = m[27], b = m[26:24], y = m[21:12], x = m[9:0].
//  Snapshot
//   - Holds {sb, sy, sx}, the last value pushed.
//   - While run = 0: no pushes, snapshot is forced to 0, pending is cleared, gap counter is cleared.
//  Change classes (evaluated every cycle with run = 1)
//   - bchg = (b != sb).
//   - mchg = ({y,x} != {sy,sx}) & ~bchg.
//  Gap counter
//   - Loads MIN_GAP on every push, then decrements to 0.
//   - gap_ok = (counter == 0).
//  Push request
//   - req = bchg | (mchg & gap_ok).
//   - A button change ignores the gap.
//   - A motion change seen while gap_ok = 0 sets pending. Pending is only informative:
//     req re-evaluates the live compare every cycle, so the latest position is pushed once
//     the gap expires. Motion is therefore coalesced, never queued twice.
//   - pending is cleared on push.
//  Push
//   - Happens when req & (~full | pop).
//   - Writes {b, y, x} at the write pointer, loads the snapshot with {b, y, x}, and reloads
//     the gap counter.
//   - Simultaneous push and pop when full is legal; level stays at DEPTH.
//  Full
//   - req while full & ~pop: no write, and ovf is set (sticky).
//   - The snapshot is not updated, so the change is retried each cycle and the newest state
//     lands as soon as a slot frees.
//   - Intermediate button edges may be lost; ovf reports this.
//  Pop
//   - pop = rd & nonempty.
//   - Advances the read pointer and clears ovf. A same-cycle overflow set wins over the clear.
//   - rd while empty is ignored entirely, including ovf.
//  Pointers
//   - AW+1-bit pointers that wrap modulo 2*DEPTH.
//   - full = (level == DEPTH); nonempty = (level != 0).
//  Head and rdata
//   - rdata is registered.
//   - Head data is valid one cycle after the write or pop that exposes it.
//   - When empty, rdata[22:0] holds the last head value and rdata[31] = 0.
//  Latency
//   - An ms_in change at edge N is registered at N+1, pushed at N+2, and visible on
//     rdata/irq at N+3.
//  Storage
//   - Register array of DEPTH x 23 bits; no reset of the array contents is required.
// TESTING
//  T1  reset, run=1, x=5 y=0 b=0 -> one event with rdata = 32'h8000_0005 at N+3;
//      rd -> irq = 0, level = 0.
//  T2  MIN_GAP=100, x ramps 1..50 at one step per cycle
//      -> pushes only at x=1 and when the gap expires, holding the latest x; ~2 entries.
//  T3  left button (b[2]) pressed, then released 3 cycles later, during an active gap
//      -> two entries, b=3'b100 then 3'b000, no gap delay.
//  T4  fill 16 entries without rd, then change b -> level = 16, ovf = 1 in rdata[30];
//      one rd -> a 17th push lands holding the latest b, ovf = 0 after the pop.
//  T5  rd and a push in the same cycle at level 16 -> level stays 16, head advances,
//      ovf stays 0; rd at level 0 -> no change.
//  T6  run dropped mid-stream, then reasserted with x=y=0 -> no event;
//      a subsequent move pushes normally. Async rst pulse mid-fill -> level = 0 immediately.

Source files
------------

// File: rtl/mouse_event_fifo_if.sv
// ---------------------------------------------------------------------------
// mouse_event_fifo_if
//   Bus bundle between the PS/2 mouse status source / CPU IO decoder and the
//   mouse event FIFO.
//   ms_in  : 28-bit live mouse status word {run, btns[2:0], 2'b0, y, 2'b0, x}
//   rd     : one-cycle pop strobe from the IO decoder
//   rdata  : {nonempty, ovf, 7'b0, btns[2:0], y[9:0], x[9:0]} of the FIFO head
//   level  : number of valid entries (0..2**AW)
//   irq    : high while the FIFO holds at least one event
//   master : the side that drives ms_in/rd and consumes rdata/level/irq
//   slave  : the FIFO itself
// ---------------------------------------------------------------------------
interface mouse_event_fifo_if #(
    parameter int AW = 4
);
    logic [27:0] ms_in;
    logic        rd;
    logic [31:0] rdata;
    logic [AW:0] level;
    logic        irq;

    modport master (
        output ms_in,
        output rd,
        input  rdata,
        input  level,
        input  irq
    );

    modport slave (
        input  ms_in,
        input  rd,
        output rdata,
        output level,
        output irq
    );
endinterface

// File: rtl/mouse_event_fifo.sv
// ---------------------------------------------------------------------------
// mouse_event_fifo
//   Watches the live PS/2 mouse status word, detects button and position
//   changes, rate-limits motion-only changes, and queues absolute-position
//   events in a small FIFO that the CPU drains through one 32-bit read port.
//   Ports:
//     clk   : system clock, rising edge
//     rst   : asynchronous, active-low reset
//     bus   : mouse_event_fifo_if.slave (ms_in, rd in; rdata, level, irq out)
//   Parameters:
//     DEPTH   : FIFO entries (power of two, >= 2)
//     AW      : log2(DEPTH)
//     MIN_GAP : minimum clk cycles between motion-only pushes (0 = no limit)
//     GW      : gap counter width, must hold MIN_GAP
// ---------------------------------------------------------------------------
module mouse_event_fifo #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int MIN_GAP = 25000,
    parameter int GW      = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    mouse_event_fifo_if.slave    bus
);

    localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   PTR_ONE_L = (AW + 1)'(1);
    localparam logic [GW-1:0] GAP_L     = GW'(MIN_GAP);
    localparam logic [GW-1:0] GAP_ONE_L = GW'(1);

    // Registered state
    logic [27:0]   m_r;        // input register
    logic [22:0]   snap_r;     // {sb, sy, sx}: last event pushed
    logic [GW-1:0] gap_r;      // motion rate-limit counter
    logic          pend_r;     // motion change waiting for the gap to expire
    logic          ovf_r;      // sticky: a change was refused because FIFO full
    logic [AW:0]   wptr_r;
    logic [AW:0]   rptr_r;
    logic [AW:0]   level_r;
    logic          irq_r;
    logic [31:0]   rdata_r;
    logic [22:0]   mem_r [DEPTH];

    // Combinational decode
    logic          run_s;
    logic [22:0]   ev_s;
    logic          bchg_s;
    logic          mchg_s;
    logic          gap_ok_s;
    logic          req_s;
    logic          full_s;
    logic          nonempty_s;
    logic          pop_s;
    logic          push_s;
    logic          block_s;
    logic          ovf_nxt_s;
    logic [AW:0]   level_nxt_s;
    logic [22:0]   head_s;

    // Pad bits of the status word and the pending flag are observed nowhere
    // else; folding them into one sink keeps their intent visible.
    logic          pad_unused_s;
    assign pad_unused_s = ^{m_r[23:22], m_r[11:10], pend_r};

    // Change detection, push/pop arbitration and next-state decode
    always_comb begin
        run_s       = m_r[27];
        ev_s        = {m_r[26:24], m_r[21:12], m_r[9:0]};
        bchg_s      = 1'b0;
        mchg_s      = 1'b0;
        req_s       = 1'b0;
        gap_ok_s    = (gap_r == '0);
        full_s      = (level_r == DEPTH_L);
        nonempty_s  = (level_r != '0);
        pop_s       = bus.rd & nonempty_s;
        level_nxt_s = level_r;
        ovf_nxt_s   = ovf_r;
        head_s      = rdata_r[22:0];

        if (run_s) begin
            bchg_s = (ev_s[22:20] != snap_r[22:20]);
            // Motion only counts when the buttons are unchanged, so a button
            // edge is never held back by the rate limit.
            mchg_s = (ev_s[19:0] != snap_r[19:0]) & ~bchg_s;
            req_s  = bchg_s | (mchg_s & gap_ok_s);
        end else begin
            bchg_s = 1'b0;
            mchg_s = 1'b0;
            req_s  = 1'b0;
        end

        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_s  = req_s & (~full_s | pop_s);
        block_s = req_s & full_s & ~pop_s;

        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + PTR_ONE_L;
            2'b01:   level_nxt_s = level_r - PTR_ONE_L;
            default: level_nxt_s = level_r;
        endcase

        // A refused change in this cycle wins over the clear from a pop.
        if (block_s) begin
            ovf_nxt_s = 1'b1;
        end else if (pop_s) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end

        // When empty, the last head value is held in rdata.
        if (nonempty_s) begin
            head_s = mem_r[rptr_r[AW-1:0]];
        end else begin
            head_s = rdata_r[22:0];
        end
    end

    // Input register, detection state, pointers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_r     <= 28'd0;
            snap_r  <= 23'd0;
            gap_r   <= '0;
            pend_r  <= 1'b0;
            ovf_r   <= 1'b0;
            wptr_r  <= '0;
            rptr_r  <= '0;
            level_r <= '0;
            irq_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            m_r <= bus.ms_in;

            if (!run_s) begin
                snap_r <= 23'd0;
                gap_r  <= '0;
                pend_r <= 1'b0;
            end else if (push_s) begin
                snap_r <= ev_s;
                gap_r  <= GAP_L;
                pend_r <= 1'b0;
            end else begin
                // Snapshot is untouched when a push is refused, so the live
                // compare keeps requesting and the newest state lands later.
                if (gap_r != '0) begin
                    gap_r <= gap_r - GAP_ONE_L;
                end
                if (mchg_s & ~gap_ok_s) begin
                    pend_r <= 1'b1;
                end
            end

            if (push_s) begin
                wptr_r <= wptr_r + PTR_ONE_L;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE_L;
            end

            level_r <= level_nxt_s;
            ovf_r   <= ovf_nxt_s;
            irq_r   <= nonempty_s;
            rdata_r <= {nonempty_s, ovf_r, 7'd0, head_s};
        end
    end

    // Event storage; contents need no reset because level gates visibility
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r[AW-1:0]] <= ev_s;
        end
    end

    assign bus.rdata = rdata_r;
    assign bus.level = level_r;
    assign bus.irq   = irq_r;

endmodule

// File: tb/tb_mouse_event_fifo.sv
// ---------------------------------------------------------------------------
// tb_mouse_event_fifo
//   Self-checking bench for mouse_event_fifo (DEPTH=16, MIN_GAP=100).
//   Expected events are queued as stimulus is driven and compared against
//   rdata as the FIFO is drained.
// ---------------------------------------------------------------------------
module tb_mouse_event_fifo;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mouse_event_fifo_if #(.AW(4)) bus ();

    mouse_event_fifo #(
        .DEPTH   (16),
        .AW      (4),
        .MIN_GAP (100),
        .GW      (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [22:0] q [$];
    logic [22:0] last_head = 23'd0;

    function automatic logic [27:0] mk(input logic run, input logic [2:0] b,
                                       input logic [9:0] y, input logic [9:0] x);
        return {run, b, 2'b00, y, 2'b00, x};
    endfunction

    function automatic logic [22:0] ev(input logic [2:0] b, input logic [9:0] y,
                                       input logic [9:0] x);
        return {b, y, x};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Pop everything, comparing each head with the scoreboard.
    task automatic drain(input string name);
        logic [22:0] exp_v;
        int k;
        k = 0;
        while (bus.irq === 1'b1 && k < 40) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL %s_extra actual=%h expected=none", name, bus.rdata[22:0]);
                last_head = bus.rdata[22:0];
            end else begin
                exp_v = q.pop_front();
                last_head = exp_v;
                if (bus.rdata[22:0] !== exp_v) begin
                    failures++;
                    $display("FAIL %s_head actual=%h expected=%h", name, bus.rdata[22:0], exp_v);
                end
            end
            bus.rd = 1'b1;
            tick();
            bus.rd = 1'b0;
            tick();
            k++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing actual=%0d expected=0", name, q.size());
        end
        checks++;
        if (bus.level !== 5'd0) begin
            failures++;
            $display("FAIL %s_level actual=%0d expected=0", name, bus.level);
        end
    endtask

    // Push n button toggles (001/010) at x=50, y=0, one per cycle.
    task automatic fill(input int n);
        logic [2:0] b;
        for (int i = 0; i < n; i++) begin
            b = (i % 2 == 1) ? 3'b010 : 3'b001;
            bus.ms_in = mk(1'b1, b, 10'd0, 10'd50);
            q.push_back(ev(b, 10'd0, 10'd50));
            tick();
        end
        idle(3);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (bus.rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_rdata actual=%h expected=%h", bus.rdata, 32'd0);
        end
        checks++;
        if (bus.level !== 5'd0) begin
            failures++;
            $display("FAIL reset_level actual=%0d expected=0", bus.level);
        end
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq actual=%b expected=0", bus.irq);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.ms_in = mk(1'b1, 3'b000, 10'd0, 10'd5);
        tick();
        tick();
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++;
            $display("FAIL single_irq_early actual=%b expected=0", bus.irq);
        end
        tick();
        checks++;
        if (bus.irq !== 1'b1) begin
            failures++;
            $display("FAIL single_irq actual=%b expected=1", bus.irq);
        end
        checks++;
        if (bus.rdata !== 32'h8000_0005) begin
            failures++;
            $display("FAIL single_rdata actual=%h expected=%h", bus.rdata, 32'h8000_0005);
        end
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        tick();
        checks++;
        if (bus.irq !== 1'b0 || bus.level !== 5'd0) begin
            failures++;
            $display("FAIL single_pop actual=irq%b/lvl%0d expected=irq0/lvl0", bus.irq, bus.level);
        end
        checks++;
        if (bus.rdata !== 32'h0000_0005) begin
            failures++;
            $display("FAIL single_hold actual=%h expected=%h", bus.rdata, 32'h0000_0005);
        end
        idle(120);
    endtask

    task automatic test_motion_coalesce();
        for (int i = 1; i <= 50; i++) begin
            bus.ms_in = mk(1'b1, 3'b000, 10'd0, 10'(i));
            tick();
        end
        q.push_back(ev(3'b000, 10'd0, 10'd1));
        q.push_back(ev(3'b000, 10'd0, 10'd50));
        idle(70);
        checks++;
        if (bus.level !== 5'd2) begin
            failures++;
            $display("FAIL motion_level actual=%0d expected=2", bus.level);
        end
        drain("motion");
    endtask

    task automatic test_button_gap();
        bus.ms_in = mk(1'b1, 3'b100, 10'd0, 10'd50);
        q.push_back(ev(3'b100, 10'd0, 10'd50));
        idle(3);
        bus.ms_in = mk(1'b1, 3'b000, 10'd0, 10'd50);
        q.push_back(ev(3'b000, 10'd0, 10'd50));
        idle(4);
        checks++;
        if (bus.level !== 5'd2) begin
            failures++;
            $display("FAIL button_level actual=%0d expected=2", bus.level);
        end
        drain("button");
    endtask

    task automatic test_overflow();
        fill(16);
        checks++;
        if (bus.level !== 5'd16) begin
            failures++;
            $display("FAIL ovf_fill_level actual=%0d expected=16", bus.level);
        end
        bus.ms_in = mk(1'b1, 3'b111, 10'd0, 10'd50);
        idle(4);
        checks++;
        if (bus.level !== 5'd16 || bus.rdata[31:30] !== 2'b11) begin
            failures++;
            $display("FAIL ovf_set actual=lvl%0d/flags%b expected=lvl16/flags11",
                     bus.level, bus.rdata[31:30]);
        end
        checks++;
        if (bus.rdata[22:0] !== q[0]) begin
            failures++;
            $display("FAIL ovf_head actual=%h expected=%h", bus.rdata[22:0], q[0]);
        end
        void'(q.pop_front());
        q.push_back(ev(3'b111, 10'd0, 10'd50));
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        tick();
        checks++;
        if (bus.level !== 5'd16) begin
            failures++;
            $display("FAIL ovf_retry_level actual=%0d expected=16", bus.level);
        end
        checks++;
        if (bus.rdata[30] !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear actual=%b expected=0", bus.rdata[30]);
        end
        drain("ovf");
    endtask

    task automatic test_back_to_back();
        fill(16);
        bus.ms_in = mk(1'b1, 3'b100, 10'd0, 10'd50);
        tick();
        checks++;
        if (bus.rdata[22:0] !== q[0]) begin
            failures++;
            $display("FAIL b2b_head actual=%h expected=%h", bus.rdata[22:0], q[0]);
        end
        void'(q.pop_front());
        q.push_back(ev(3'b100, 10'd0, 10'd50));
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        tick();
        checks++;
        if (bus.level !== 5'd16 || bus.rdata[30] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_level actual=lvl%0d/ovf%b expected=lvl16/ovf0",
                     bus.level, bus.rdata[30]);
        end
        checks++;
        if (bus.rdata[22:0] !== q[0]) begin
            failures++;
            $display("FAIL b2b_advance actual=%h expected=%h", bus.rdata[22:0], q[0]);
        end
        drain("b2b");
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        tick();
        checks++;
        if (bus.level !== 5'd0 || bus.irq !== 1'b0) begin
            failures++;
            $display("FAIL empty_rd actual=lvl%0d/irq%b expected=lvl0/irq0", bus.level, bus.irq);
        end
        checks++;
        if (bus.rdata !== {9'd0, last_head}) begin
            failures++;
            $display("FAIL empty_rdata actual=%h expected=%h", bus.rdata, {9'd0, last_head});
        end
    endtask

    task automatic test_run_and_rst();
        bus.ms_in = mk(1'b0, 3'b101, 10'd3, 10'd77);
        idle(5);
        checks++;
        if (bus.level !== 5'd0 || bus.irq !== 1'b0) begin
            failures++;
            $display("FAIL run_off actual=lvl%0d/irq%b expected=lvl0/irq0", bus.level, bus.irq);
        end
        bus.ms_in = mk(1'b1, 3'b000, 10'd0, 10'd0);
        idle(5);
        checks++;
        if (bus.level !== 5'd0) begin
            failures++;
            $display("FAIL run_on_zero actual=%0d expected=0", bus.level);
        end
        bus.ms_in = mk(1'b1, 3'b000, 10'd0, 10'd9);
        q.push_back(ev(3'b000, 10'd0, 10'd9));
        idle(3);
        checks++;
        if (bus.level !== 5'd1 || bus.irq !== 1'b1) begin
            failures++;
            $display("FAIL run_move actual=lvl%0d/irq%b expected=lvl1/irq1", bus.level, bus.irq);
        end
        drain("run");
        for (int i = 0; i < 6; i++) begin
            bus.ms_in = mk(1'b1, (i % 2 == 1) ? 3'b010 : 3'b001, 10'd0, 10'd9);
            tick();
        end
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.level !== 5'd0 || bus.irq !== 1'b0 || bus.rdata !== 32'd0) begin
            failures++;
            $display("FAIL async_rst actual=lvl%0d/irq%b/%h expected=lvl0/irq0/0",
                     bus.level, bus.irq, bus.rdata);
        end
        bus.ms_in = 28'd0;
        idle(2);
        rst = 1'b1;
        tick();
        q.delete();
    endtask

    initial begin
        bus.ms_in = 28'd0;
        bus.rd    = 1'b0;
        test_reset();
        test_single();
        test_motion_coalesce();
        test_button_gap();
        test_overflow();
        test_back_to_back();
        test_run_and_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
